// File: rtl/ureg_n_if.sv
// ureg_n_if: control and data bundle for the ureg_n universal register.
//   master drives: clr (sync clear), en (clock enable), mode (00 hold,
//                  01 shift right, 10 shift left, 11 load), d (load data),
//                  sin (serial in)
//   slave drives:  q (contents), sout (last bit shifted out),
//                  cnt (shifts since load/clear), drained (cnt == WIDTH)
interface ureg_n_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             clr;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [CW-1:0]    cnt;
    logic             drained;

    modport master (
        output clr, en, mode, d, sin,
        input  q, sout, cnt, drained
    );

    modport slave (
        input  clr, en, mode, d, sin,
        output q, sout, cnt, drained
    );
endinterface

// File: rtl/ureg_n.sv
// ureg_n: WIDTH-bit universal register (hold / shift right / shift left /
// parallel load) with serial in/out, synchronous clear, asynchronous
// active-low reset and a saturating count of bits shifted out.
//   clk   : clock; active edge is falling when NEG_EDGE=1, rising otherwise
//   clr_n : asynchronous active-low reset
//   bus   : ureg_n_if slave (clr, en, mode, d, sin -> q, sout, cnt, drained)
module ureg_n #(
    parameter int WIDTH    = 8,
    parameter bit NEG_EDGE = 1'b1
) (
    input  logic   clk,
    input  logic   clr_n,
    ureg_n_if.slave bus
);
    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_r, q_nx;
    logic             sout_r, sout_nx;
    logic [CW-1:0]    cnt_r, cnt_nx;
    logic [CW-1:0]    cnt_inc;

    // Count saturates at WIDTH; shifting itself keeps going.
    assign cnt_inc = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CW'(1);

    always_comb begin
        q_nx    = q_r;
        sout_nx = sout_r;
        cnt_nx  = cnt_r;
        if (bus.clr) begin
            q_nx    = '0;
            sout_nx = 1'b0;
            cnt_nx  = '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHR: begin
                    sout_nx = q_r[0];
                    q_nx    = {bus.sin, q_r[WIDTH-1:1]};
                    cnt_nx  = cnt_inc;
                end
                MODE_SHL: begin
                    sout_nx = q_r[WIDTH-1];
                    q_nx    = {q_r[WIDTH-2:0], bus.sin};
                    cnt_nx  = cnt_inc;
                end
                MODE_LOAD: begin
                    // sout deliberately keeps the last shifted-out bit.
                    q_nx   = bus.d;
                    cnt_nx = '0;
                end
                MODE_HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Only one of these branches is elaborated, so the state has one driver.
    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    q_r    <= '0;
                    sout_r <= 1'b0;
                    cnt_r  <= '0;
                end else begin
                    q_r    <= q_nx;
                    sout_r <= sout_nx;
                    cnt_r  <= cnt_nx;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    q_r    <= '0;
                    sout_r <= 1'b0;
                    cnt_r  <= '0;
                end else begin
                    q_r    <= q_nx;
                    sout_r <= sout_nx;
                    cnt_r  <= cnt_nx;
                end
            end
        end
    endgenerate

    assign bus.q       = q_r;
    assign bus.sout    = sout_r;
    assign bus.cnt     = cnt_r;
    assign bus.drained = (cnt_r == CNT_MAX);
endmodule
